// File: rtl/usb_uart_echo_buffer.sv
// Buffered USB serial loopback: FIFO with valid/ready on both sides,
// optional line-buffered release, ASCII case transform and debug counters.
module usb_uart_echo_buffer #(
   parameter int         DEPTH       = 64,
   parameter logic [7:0] TERMINATOR  = 8'h0D,
   parameter int         COUNT_WIDTH = 16
) (
   input  logic                     clk_48mhz,
   input  logic                     reset,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   input  logic                     line_mode,
   input  logic [1:0]               case_mode,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   level,
   output logic [COUNT_WIDTH-1:0]   echo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   localparam logic [LW-1:0] ONE  = LW'(1);

   // Pointers carry one extra wrap bit so full and empty stay distinct
   logic [7:0]    mem [DEPTH];
   logic [LW-1:0] wr_ptr;
   logic [LW-1:0] rd_ptr;
   logic [LW-1:0] commit_ptr;
   logic [LW-1:0] level_q;

   logic [LW-1:0] wr_nxt;
   logic [LW-1:0] commit_nxt;
   logic [LW-1:0] level_nxt;
   logic          rx_fire;
   logic          tx_fire;
   logic          out_free;
   logic          head_load;
   logic          full_commit;
   logic [7:0]    rx_xf;
   logic [7:0]    head_data;

   function automatic logic [7:0] xform(input logic [7:0] d,
                                        input logic [1:0] m);
      logic up;
      logic lo;
      up = (d >= 8'h41) && (d <= 8'h5A);
      lo = (d >= 8'h61) && (d <= 8'h7A);
      xform = d;
      case (m)
         2'b01:   if (lo) xform = d & 8'hDF;
         2'b10:   if (up) xform = d | 8'h20;
         2'b11:   if (up || lo) xform = d ^ 8'h20;
         default: xform = d;
      endcase
   endfunction

   assign rx_ready = !reset && !flush && (level_q != FULL);
   assign rx_fire  = rx_valid && rx_ready;
   assign tx_fire  = tx_valid && tx_ready;
   assign out_free = !tx_valid || tx_ready;
   assign rx_xf    = xform(rx_data, case_mode);
   assign wr_nxt   = rx_fire ? wr_ptr + ONE : wr_ptr;
   assign level    = level_q;

   // Force a commit when an uncommitted line would otherwise fill the FIFO
   assign full_commit = rx_fire && (level_q == FULL - ONE) &&
                        !(out_free && (rd_ptr != commit_ptr));

   always_comb begin
      commit_nxt = commit_ptr;
      if (!line_mode)
         commit_nxt = wr_nxt;
      else if (rx_fire && ((rx_data == TERMINATOR) || full_commit))
         commit_nxt = wr_nxt;
   end

   assign head_load = out_free && (rd_ptr != commit_nxt);

   // Bypass: an empty FIFO forwards this cycle's byte straight to the output
   assign head_data = (rd_ptr == wr_ptr) ? rx_xf : mem[rd_ptr[AW-1:0]];

   always_comb begin
      level_nxt = level_q;
      if (rx_fire && !head_load)
         level_nxt = level_q + ONE;
      else if (!rx_fire && head_load)
         level_nxt = level_q - ONE;
   end

   always_ff @(posedge clk_48mhz) begin
      if (rx_fire)
         mem[wr_ptr[AW-1:0]] <= rx_xf;
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         commit_ptr <= '0;
         level_q    <= '0;
         tx_valid   <= 1'b0;
         tx_data    <= 8'h00;
         echo_count <= '0;
      end else begin
         if (tx_fire)
            echo_count <= echo_count + COUNT_WIDTH'(1);
         if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            commit_ptr <= '0;
            level_q    <= '0;
            tx_valid   <= 1'b0;
         end else begin
            wr_ptr     <= wr_nxt;
            commit_ptr <= commit_nxt;
            level_q    <= level_nxt;
            if (head_load) begin
               tx_data  <= head_data;
               tx_valid <= 1'b1;
               rd_ptr   <= rd_ptr + ONE;
            end else if (tx_fire) begin
               tx_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/usb_uart_echo_buffer.md
Name: usb_uart_echo_buffer

Overview:
- Parametrised, buffered successor to the single-register USB serial loopback.
- Sits between the usb_uart receive stream (host->device bytes) and its transmit stream (device->host bytes).
- Provides a DEPTH-entry FIFO with full valid/ready backpressure, an optional line-buffered release mode and a selectable ASCII case transform.
- Reports occupancy and a running echo count for debug/LED use.

Parameters:
DEPTH, 64, FIFO entries; power of two, 4..4096.
TERMINATOR, 8'h0D, byte value that commits a line in line mode.
COUNT_WIDTH, 16, width of echo_count.

Ports:
clk_48mhz  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
rx_data  input  8  byte from usb_uart (uart_out_data)
rx_valid  input  1  rx_data valid (uart_out_valid)
rx_ready  output  1  block accepts rx byte this cycle (uart_out_ready)
tx_data  output  8  byte to usb_uart (uart_in_data)
tx_valid  output  1  tx_data valid (uart_in_valid)
tx_ready  input  1  usb_uart accepts tx byte (uart_in_ready)
line_mode  input  1  0 = stream release, 1 = release only committed lines
case_mode  input  2  00 pass, 01 upper, 10 lower, 11 toggle case
flush  input  1  synchronous discard of all buffered data
level  output  $clog2(DEPTH)+1  FIFO entries held, excluding the output register
echo_count  output  COUNT_WIDTH  bytes accepted on tx, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Clock and reset: one clock (clk_48mhz); reset is synchronous and active-high.
- Reset values: tx_valid=0, tx_data=0, level=0, echo_count=0, all pointers 0, commit pointer 0. rx_ready=0 during the reset cycle.
- Handshake: a transfer occurs on any cycle where valid && ready.
  - rx_ready = !reset && !flush && (level != DEPTH); combinational from registered state only, never from rx_valid.
  - tx_data is held stable while tx_valid=1 && tx_ready=0.
  - tx_valid never drops without a transfer, except on reset or flush.
- Write side: each accepted byte is transformed, then stored at wr_ptr; wr_ptr increments, wrapping at DEPTH.
  - Transform applies only to 8'h41-8'h5A and 8'h61-8'h7A; all other values pass unchanged.
  - 01: a-z -> A-Z. 10: A-Z -> a-z. 11: XOR 8'h20 on letters.
  - case_mode is sampled on the accept cycle.
- Commit pointer:
  - line_mode=0: commit_ptr tracks wr_ptr each cycle, including the byte written this cycle.
  - line_mode=1: commit_ptr jumps to the post-write wr_ptr when the accepted byte (pre-transform) equals TERMINATOR, or when the write makes level==DEPTH (deadlock avoidance).
  - line_mode 1->0: the uncommitted bytes are released from the next cycle.
  - line_mode 0->1: everything already written stays committed.
- Read side: one output register stage.
  - When the output register is empty, or is transferring this cycle, and rd_ptr != commit_ptr, the head loads into tx_data next cycle with tx_valid=1, and rd_ptr increments.
  - Sustained throughput is 1 byte/cycle when tx_ready stays high.
- Latency: an rx byte accepted in cycle N with the FIFO empty and line_mode=0 has tx_valid=1 in cycle N+1.
- level: +1 on rx accept, -1 on head load; simultaneous accept and load leaves it unchanged.
- echo_count increments on each tx transfer.
- Full: rx_ready=0 until a head load frees an entry. A same-cycle load does not re-enable rx_ready that cycle, because rx_ready derives from registered level.
- Empty / uncommitted: tx_valid stays 0 after the output register drains.
- flush: next cycle wr_ptr = rd_ptr = commit_ptr = 0, level=0, tx_valid=0.
  - An rx byte presented during flush is not accepted.
  - echo_count is unaffected.
  - flush has priority over all other events.
- Reset mid-transfer: everything returns to the reset values; no partial byte is emitted.

Test Plan:
- Stream echo: line_mode=0, case_mode=00, tx_ready=1; send 8'h41, 8'h62 on consecutive cycles -> tx shows 8'h41, 8'h62 in cycles N+1 and N+2; echo_count=2; level returns to 0.
- Backpressure/full: DEPTH=4, tx_ready=0, send 6 bytes 1..6 -> bytes 1..5 accepted (1 in output register, 4 in FIFO), rx_ready=0, level=4. Then tx_ready=1 -> output 1..5 in order, no loss or duplication, then byte 6 accepted.
- Line mode: line_mode=1; send "hi" (8'h68, 8'h69) -> tx_valid stays 0. Send 8'h0D -> 8'h68, 8'h69, 8'h0D emitted back-to-back.
- Case transform: case_mode=11; send 8'h61, 8'h5A, 8'h31 -> tx 8'h41, 8'h7A, 8'h31. case_mode=01; send 8'h7B -> tx 8'h7B unchanged.
- Flush and reset: buffer 3 uncommitted bytes in line mode, pulse flush one cycle -> level=0, tx_valid=0; a following 8'h0D is emitted alone. Assert reset during a stalled tx -> tx_valid=0 and echo_count=0 the next cycle.
- Random soak: random rx_valid/tx_ready at 50% over 10k bytes, random line_mode toggles -> scoreboard order matches input with transform applied, and no overflow when rx_ready=0.
